fb_scanout: RTL and testbench
=============================

# fb_scanout

Frame-buffer reader and VGA scanout engine: the read side of the GPU's double-buffered frame store, consuming the 9-bit RGB333 pixels that the rasterizer writes. It generates 640x480@60 timing from `clk`, fetches pixels from the front buffer over a 1-cycle-latency read port, and drives RGB and sync outputs. It owns the double-buffer swap handshake: a finished frame from the writer is flipped to the front only at vertical blanking, and only after a configurable minimum number of displayed frames.

## Interface
- `FB_W`, 320, frame-buffer width in pixels (row stride)
- `FB_H`, 240, frame-buffer height in pixels
- `FRAME_HOLD`, 1, minimum displayed frames per buffer before a swap is allowed (1..15)
- `clk`  in  1  pixel clock, 25.175 MHz nominal
- `reset`  in  1  synchronous, active-high
- `frame_done`  in  1  writer's level "back buffer fully drawn"
- `swap_ack`  out  1  one-cycle pulse; buffers flipped this cycle
- `back_sel`  out  1  buffer index the writer may draw into (= ~front select)
- `rd_buf`  out  1  buffer index of the current read
- `rd_addr`  out  $clog2(FB_W*FB_H)  pixel index y*FB_W+x within buffer
- `rd_data`  in  9  RGB333 pixel, valid the cycle after `rd_addr`
- `vga_r`, `vga_g`, `vga_b`  out  3 each  colour, zero outside active video
- `vga_hs_n`, `vga_vs_n`  out  1  active-low syncs
- `vga_de`  out  1  active-video enable

## Operation
- Timing: h_cnt 0..799 (active 0..639, front porch 16, sync 656..751, back porch 48); v_cnt 0..524 (active 0..479, sync 490..491). v_cnt advances when h_cnt wraps 799->0; v_cnt wraps 524->0.
- Pixel mapping: fb_x = h_cnt, fb_y = v_cnt (1:1). In-region when fb_x<FB_W and fb_y<FB_H and active; elsewhere rd_addr holds and RGB output is 0 (black border).
- rd_addr = fb_y*FB_W + fb_x, computed incrementally (row base register + column counter); no multiplier.
- Swap FSM states: SHOW (hold counter counting frames), PEND (frame_done seen, waiting for hold count and vblank), FLIP (single cycle).
  - SHOW: hold_cnt increments at each vblank start (v_cnt==480, h_cnt==0), saturating at FRAME_HOLD. frame_done high -> PEND.
  - PEND: at vblank start with hold_cnt>=FRAME_HOLD -> FLIP.
  - FLIP: toggle front select, pulse swap_ack, clear hold_cnt, -> SHOW.
- frame_done high in the same cycle as vblank start while in SHOW with hold satisfied: swap occurs at that vblank (the request is latched and the check applied in the same cycle).
- frame_done is ignored in PEND and FLIP; the writer deasserts it after swap_ack.
- Swap never occurs during active video; front select is constant for a whole displayed frame.
- Reset mid-frame: all counters restart at (0,0) on the next cycle; front select returns to 0; a pending swap is discarded.

## Timing
- Reset values: h_cnt=v_cnt=0, vga_hs_n=vga_vs_n=1, vga_de=0, RGB=0, rd_addr=0, rd_buf=0, back_sel=1, swap_ack=0, state SHOW, hold_cnt=0.
- Pipeline: stage 0 counters/rd_addr, stage 1 memory returns rd_data, stage 2 registered RGB. hs/vs/de/in-region are delayed 2 cycles so all outputs align; RGB appears 2 cycles after its rd_addr.
- swap_ack asserts in the cycle after the vblank-start cycle; back_sel and rd_buf change in that same cycle.

## Configuration
- `FB_PIXEL_DOUBLE_EN` defined: fb_x = h_cnt>>1, fb_y = v_cnt>>1; each fb pixel is 2x2 on screen; a 320x240 buffer fills 640x480. rd_addr repeats each pixel for 2 cycles and each row for 2 lines (row base advances on odd lines only).
- Undefined: 1:1 mapping with black border as above.

## Structure
- `gpu_pkg`: `rgb9_t` (packed r/g/b 3 bits), VGA timing localparams (H/V active, porch, sync, total), `swap_state_e`.
- Sub-module `vga_timing`: h/v counters, raw syncs, active flag, vblank-start strobe. `fb_scanout` holds address generation, swap FSM, and output pipeline.

## Test plan
- Reset release -> first hsync low at h_cnt 656 (cycle 658 at output), line period 800 cycles, frame 420000 cycles.
- Memory model returns rd_data = addr[8:0]; 1:1 mode -> pixel (5,2) outputs RGB = (2*320+5)[8:0] exactly 2 cycles after its rd_addr; pixel (330,10) outputs black.
- `FB_PIXEL_DOUBLE_EN` -> screen (0..1, 0..1) all show fb pixel 0; screen (639,479) reads rd_addr 76799.
- FRAME_HOLD=1, frame_done raised mid-frame -> swap_ack one cycle after next vblank start, back_sel 1->0, rd_buf 0->1.
- FRAME_HOLD=3, frame_done held after a swap -> next swap_ack exactly 3 frames later (1,260,000 cycles), not earlier.
- Reset asserted at (300,200) in PEND -> no swap_ack, rd_buf=0, counters restart at 0.

Source files
------------

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared types and VGA 640x480@60 timing constants for the scanout path
//
// Purpose : pixel type, default raster timing and swap-FSM state encoding used by
//           vga_timing and fb_scanout.
// Ports   : none (package).
package gpu_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb9_t;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC_W = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC_W + H_BACK;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC_W = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC_W + V_BACK;

  typedef enum logic [1:0] {
    SHOW = 2'd0,
    PEND = 2'd1,
    FLIP = 2'd2
  } swap_state_e;

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - horizontal/vertical raster counters and raw sync generation
//
// Purpose : free-running h/v counters for the display raster.
// Ports   : clk, reset (sync, active-high)
//           h_cnt, v_cnt      current raster position
//           hs_n, vs_n        undelayed active-low syncs
//           active            position lies in the visible area
//           line_end          last cycle of a line (h_cnt wraps next cycle)
//           frame_end         last cycle of a frame
//           vblank_start      first cycle of the first blank line
module vga_timing
  import gpu_pkg::*;
#(
  parameter int H_ACT = H_ACTIVE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SW  = H_SYNC_W,
  parameter int H_BP  = H_BACK,
  parameter int V_ACT = V_ACTIVE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SW  = V_SYNC_W,
  parameter int V_BP  = V_BACK
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hs_n,
  output logic       vs_n,
  output logic       active,
  output logic       line_end,
  output logic       frame_end,
  output logic       vblank_start
);

  localparam logic [9:0] H_LAST = 10'(H_ACT + H_FP + H_SW + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACT + V_FP + V_SW + V_BP - 1);
  localparam logic [9:0] H_A    = 10'(H_ACT);
  localparam logic [9:0] V_A    = 10'(V_ACT);
  localparam logic [9:0] HS_BEG = 10'(H_ACT + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACT + H_FP + H_SW);
  localparam logic [9:0] VS_BEG = 10'(V_ACT + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACT + V_FP + V_SW);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign line_end     = (h_cnt == H_LAST);
  assign frame_end    = line_end && (v_cnt == V_LAST);
  assign hs_n         = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_n         = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  assign active       = (h_cnt < H_A) && (v_cnt < V_A);
  assign vblank_start = (v_cnt == V_A) && (h_cnt == 10'd0);

endmodule

// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - frame-buffer reader, double-buffer swap control and VGA output
//
// Purpose : reads RGB333 pixels from the front buffer in raster order and drives
//           VGA colour/sync; flips front/back buffers at vblank once the writer
//           reports a finished frame and the current front has been shown for at
//           least FRAME_HOLD frames.
// Ports   : clk, reset (sync, active-high)
//           frame_done  in   writer's "back buffer drawn" level
//           swap_ack    out  one-cycle pulse in the cycle the buffers flip
//           back_sel    out  buffer the writer may draw into
//           rd_buf      out  buffer being read
//           rd_addr     out  pixel index y*FB_W+x, data returns next cycle
//           rd_data     in   RGB333 pixel for last cycle's rd_addr
//           vga_r/g/b, vga_hs_n, vga_vs_n, vga_de  display outputs
// Options : FB_PIXEL_DOUBLE_EN - each buffer pixel covers 2x2 screen pixels.
module fb_scanout
  import gpu_pkg::*;
#(
  parameter int FB_W       = 320,
  parameter int FB_H       = 240,
  parameter int FRAME_HOLD = 1,
  parameter int H_ACT      = H_ACTIVE,
  parameter int H_FP       = H_FRONT,
  parameter int H_SW       = H_SYNC_W,
  parameter int H_BP       = H_BACK,
  parameter int V_ACT      = V_ACTIVE,
  parameter int V_FP       = V_FRONT,
  parameter int V_SW       = V_SYNC_W,
  parameter int V_BP       = V_BACK,
  localparam int AW        = $clog2(FB_W * FB_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_done,
  output logic          swap_ack,
  output logic          back_sel,
  output logic          rd_buf,
  output logic [AW-1:0] rd_addr,
  input  logic [8:0]    rd_data,
  output logic [2:0]    vga_r,
  output logic [2:0]    vga_g,
  output logic [2:0]    vga_b,
  output logic          vga_hs_n,
  output logic          vga_vs_n,
  output logic          vga_de
);

  localparam logic [9:0]    FB_W_C    = 10'(FB_W);
  localparam logic [9:0]    FB_H_C    = 10'(FB_H);
  localparam logic [AW-1:0] ROW_STEP  = AW'(FB_W);
  localparam logic [AW-1:0] LAST_BASE = AW'((FB_H - 1) * FB_W);
  localparam logic [3:0]    HOLD_MAX  = 4'(FRAME_HOLD);

  logic [9:0] h_cnt, v_cnt;
  logic       hs_raw_n, vs_raw_n, active, line_end, frame_end, vblank_start;

  vga_timing #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
  ) u_timing (
    .clk          (clk),
    .reset        (reset),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .hs_n         (hs_raw_n),
    .vs_n         (vs_raw_n),
    .active       (active),
    .line_end     (line_end),
    .frame_end    (frame_end),
    .vblank_start (vblank_start)
  );

  // ---------------- address generation (stage 0) ----------------
  logic [9:0]    fb_x, fb_y;
  logic          row_adv;
  logic          in_region;
  logic [AW-1:0] row_base, addr_hold;

`ifdef FB_PIXEL_DOUBLE_EN
  assign fb_x    = h_cnt >> 1;
  assign fb_y    = v_cnt >> 1;
  assign row_adv = v_cnt[0];      // each buffer row is shown on two lines
`else
  assign fb_x    = h_cnt;
  assign fb_y    = v_cnt;
  assign row_adv = 1'b1;
`endif

  assign in_region = active && (fb_x < FB_W_C) && (fb_y < FB_H_C);

  // Row base stops at the last buffer row so it never runs past the buffer on
  // lines below the picture; it is rebased at every frame wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_base <= '0;
    end else if (frame_end) begin
      row_base <= '0;
    end else if (line_end && row_adv && (row_base != LAST_BASE)) begin
      row_base <= row_base + ROW_STEP;
    end
  end

  // Outside the picture the address parks on the last fetched pixel.
  assign rd_addr = in_region ? (row_base + AW'(fb_x)) : addr_hold;

  always_ff @(posedge clk) begin
    if (reset) addr_hold <= '0;
    else       addr_hold <= rd_addr;
  end

  // ---------------- swap FSM ----------------
  swap_state_e state, state_nxt;
  logic [3:0]  hold_cnt;
  logic        front_sel;
  logic        hold_ok;

  // The frame ending at this vblank counts toward the hold, so the check uses
  // the post-increment count.
  assign hold_ok = ({1'b0, hold_cnt} + 5'd1) >= 5'(FRAME_HOLD);

  always_comb begin
    state_nxt = state;
    swap_ack  = 1'b0;
    case (state)
      SHOW: if (frame_done) state_nxt = (vblank_start && hold_ok) ? FLIP : PEND;
      PEND: if (vblank_start && hold_ok) state_nxt = FLIP;
      FLIP: begin
        swap_ack  = 1'b1;
        state_nxt = SHOW;
      end
      default: state_nxt = SHOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SHOW;
      hold_cnt  <= '0;
      front_sel <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FLIP)
        hold_cnt <= '0;
      else if (vblank_start && (hold_cnt != HOLD_MAX))
        hold_cnt <= hold_cnt + 4'd1;
      // Toggling on entry makes the new front visible in the swap_ack cycle.
      if (state_nxt == FLIP)
        front_sel <= ~front_sel;
    end
  end

  assign rd_buf   = front_sel;
  assign back_sel = ~front_sel;

  // ---------------- output pipeline (stages 1 and 2) ----------------
  logic  de_d1, hs_d1, vs_d1, reg_d1;
  rgb9_t pix;

  assign pix = rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      de_d1    <= 1'b0;
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
      reg_d1   <= 1'b0;
      vga_de   <= 1'b0;
      vga_hs_n <= 1'b1;
      vga_vs_n <= 1'b1;
      vga_r    <= '0;
      vga_g    <= '0;
      vga_b    <= '0;
    end else begin
      de_d1    <= active;
      hs_d1    <= hs_raw_n;
      vs_d1    <= vs_raw_n;
      reg_d1   <= in_region;
      vga_de   <= de_d1;
      vga_hs_n <= hs_d1;
      vga_vs_n <= vs_d1;
      vga_r    <= reg_d1 ? pix.r : 3'd0;
      vga_g    <= reg_d1 ? pix.g : 3'd0;
      vga_b    <= reg_d1 ? pix.b : 3'd0;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - directed scoreboard bench for fb_scanout
module tb_fb_scanout;

  localparam int FB_W  = 320;
  localparam int FB_H  = 240;
  localparam int HT    = 800;
  localparam int V_ACT = 6;
  localparam int V_FP  = 1;
  localparam int V_SW  = 1;
  localparam int V_BP  = 2;
  localparam int VT    = V_ACT + V_FP + V_SW + V_BP;
  localparam int AW    = $clog2(FB_W * FB_H);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          fd1, sa1, bs1, rb1, hs1, vs1, de1;
  logic [AW-1:0] addr1;
  logic [8:0]    data1;
  logic [2:0]    r1, g1, b1;

  logic          fd3, sa3, bs3, rb3, hs3, vs3, de3;
  logic [AW-1:0] addr3;
  logic [8:0]    data3;
  logic [2:0]    r3, g3, b3;

  fb_scanout #(
    .FB_W(FB_W), .FB_H(FB_H), .FRAME_HOLD(1),
    .H_ACT(640), .H_FP(16), .H_SW(96), .H_BP(48),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
  ) dut (
    .clk(clk), .reset(reset), .frame_done(fd1), .swap_ack(sa1),
    .back_sel(bs1), .rd_buf(rb1), .rd_addr(addr1), .rd_data(data1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .vga_hs_n(hs1), .vga_vs_n(vs1), .vga_de(de1)
  );

  fb_scanout #(
    .FB_W(FB_W), .FB_H(FB_H), .FRAME_HOLD(3),
    .H_ACT(640), .H_FP(16), .H_SW(96), .H_BP(48),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
  ) dut3 (
    .clk(clk), .reset(reset), .frame_done(fd3), .swap_ack(sa3),
    .back_sel(bs3), .rd_buf(rb3), .rd_addr(addr3), .rd_data(data3),
    .vga_r(r3), .vga_g(g3), .vga_b(b3),
    .vga_hs_n(hs3), .vga_vs_n(vs3), .vga_de(de3)
  );

  // Memory model: 1-cycle read latency, data = low address bits.
  always @(posedge clk) begin
    data1 <= addr1[8:0];
    data3 <= addr3[8:0];
  end

  int total = 0;
  int bad = 0;
  int n;
  bit sb_on = 1'b0;
  int last_addr;
  logic hs_prev, vs_prev;
  logic [11:0] sb[$];
  int sa1_q[$];
  int sa3_q[$];
  int hs_fall[$];
  int vs_fall[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  // Reference raster model for cycle c counted from reset release.
  task automatic model(input int c, output logic inreg, output int addr,
                       output logic de, output logic hs_n, output logic vs_n);
    int h, v, fx, fy;
    h = c % HT;
    v = (c / HT) % VT;
`ifdef FB_PIXEL_DOUBLE_EN
    fx = h / 2;
    fy = v / 2;
`else
    fx = h;
    fy = v;
`endif
    de    = (h < 640) && (v < V_ACT);
    hs_n  = !((h >= 656) && (h < 752));
    vs_n  = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SW));
    inreg = de && (fx < FB_W) && (fy < FB_H);
    addr  = fy * FB_W + fx;
  endtask

  task automatic sample();
    logic ir, de, hs, vs;
    int a;
    logic [11:0] e;
    if (sa1 === 1'b1) sa1_q.push_back(n);
    if (sa3 === 1'b1) sa3_q.push_back(n);
    if (hs_prev && !hs1) hs_fall.push_back(n);
    if (vs_prev && !vs1) vs_fall.push_back(n);
    hs_prev = hs1;
    vs_prev = vs1;
    if (sb_on) begin
      model(n, ir, a, de, hs, vs);
      if (ir) last_addr = a;
      check("rd_addr", 32'(addr1), 32'(last_addr));
      sb.push_back({de, hs, vs, ir ? 9'(a) : 9'd0});
      e = sb.pop_front();
      check("sb_out", 32'({de1, hs1, vs1, r1, g1, b1}), 32'(e));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    sample();
  endtask

  task automatic run_to(input int t);
    while (n < t) step();
  endtask

  task automatic start_run();
    n = 0;
    last_addr = 0;
    hs_prev = 1'b1;
    vs_prev = 1'b1;
    sb.delete();
    sb.push_back(12'h600);   // two reset-valued outputs fill the pipeline
    sb.push_back(12'h600);
    sa1_q.delete();
    sa3_q.delete();
    hs_fall.delete();
    vs_fall.delete();
    sb_on = 1'b1;
    sample();
  endtask

  initial begin
    int exp_a52, exp_rgb52, exp_a_330, exp_rgb_330, exp_a_11;
`ifdef FB_PIXEL_DOUBLE_EN
    exp_a52 = 322; exp_rgb52 = 322; exp_a_330 = 485; exp_rgb_330 = 485; exp_a_11 = 0;
`else
    exp_a52 = 645; exp_rgb52 = 133; exp_a_330 = 959; exp_rgb_330 = 0; exp_a_11 = 321;
`endif
    n = 0;
    fd1 = 1'b0;
    fd3 = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hs_n", 32'(hs1), 1);
    check("rst_vs_n", 32'(vs1), 1);
    check("rst_de", 32'(de1), 0);
    check("rst_rgb", 32'({r1, g1, b1}), 0);
    check("rst_addr", 32'(addr1), 0);
    check("rst_rd_buf", 32'(rb1), 0);
    check("rst_back_sel", 32'(bs1), 1);
    check("rst_swap_ack", 32'(sa1), 0);

    reset = 1'b0;
    fd3 = 1'b1;
    start_run();

    run_to(801);
    check("addr_1_1", 32'(addr1), 32'(exp_a_11));
    run_to(999);
    fd1 = 1'b1;
    run_to(1605);
    check("addr_5_2", 32'(addr1), 32'(exp_a52));
    run_to(1607);
    check("rgb_5_2", 32'({r1, g1, b1}), 32'(exp_rgb52));
    run_to(1930);
    check("addr_330_2", 32'(addr1), 32'(exp_a_330));
    run_to(1932);
    check("rgb_330_2", 32'({r1, g1, b1}), 32'(exp_rgb_330));
    run_to(2000);
    sb_on = 1'b0;
    check("hs_first", 32'(hs_fall.size() > 0 ? hs_fall[0] : -1), 658);
    check("line_period", 32'(hs_fall.size() > 1 ? hs_fall[1] - hs_fall[0] : -1), 800);

    run_to(4800);
    check("pre_swap_back_sel", 32'(bs1), 1);
    check("pre_swap_rd_buf", 32'(rb1), 0);
    check("pre_swap_ack", 32'(sa1), 0);
    run_to(4801);
    check("swap_ack", 32'(sa1), 1);
    check("swap_back_sel", 32'(bs1), 0);
    check("swap_rd_buf", 32'(rb1), 1);
    fd1 = 1'b0;
    run_to(4802);
    check("swap_ack_pulse", 32'(sa1), 0);

    run_to(45000);
    check("frame_period", 32'(vs_fall.size() > 1 ? vs_fall[1] - vs_fall[0] : -1), 8000);
    check("vs_first", 32'(vs_fall.size() > 0 ? vs_fall[0] : -1), 5602);
    check("hold1_swaps", 32'(sa1_q.size()), 1);
    check("hold3_swaps", 32'(sa3_q.size()), 2);
    check("hold3_first", 32'(sa3_q.size() > 0 ? sa3_q[0] : -1), 20801);
    check("hold3_gap", 32'(sa3_q.size() > 1 ? sa3_q[1] - sa3_q[0] : -1), 24000);

    run_to(46000);
    fd1 = 1'b1;                  // dut moves to PEND, swap due at 52800
    run_to(50700);               // raster at (300,3)
    reset = 1'b1;
    fd1 = 1'b0;
    fd3 = 1'b0;
    step();
    check("mid_rst_addr", 32'(addr1), 0);
    check("mid_rst_rd_buf", 32'(rb1), 0);
    check("mid_rst_back_sel", 32'(bs1), 1);
    check("mid_rst_hs_n", 32'(hs1), 1);
    reset = 1'b0;
    start_run();
    run_to(1000);
    sb_on = 1'b0;
    run_to(9000);
    check("mid_rst_no_swap", 32'(sa1_q.size()), 0);
    check("mid_rst_rd_buf_hold", 32'(rb1), 0);
    check("mid_rst_hs_first", 32'(hs_fall.size() > 0 ? hs_fall[0] : -1), 658);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
